// File: rtl/bcd_countdown_2digits.sv
// Two-digit BCD down-counter with load, enable and optional auto-reload.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   reset      - synchronous, active-high; clears count, reload and done, returns to IDLE
//   load       - capture load_value this edge (beats enable)
//   load_value - BCD {tens[7:4], ones[3:0]}; each nibble above 9 is clamped to 9
//   enable     - count-down tick qualifier, only acts in RUN
//   count      - registered BCD value {tens, ones}
//   zero       - combinational decode of count == 8'h00
//   done       - registered one-cycle pulse on the 01 -> 00 expiry edge
//   busy       - high while the FSM is in RUN
//
// Parameter:
//   AUTO_RELOAD - 0: stop at 00 after expiry; 1: stay in RUN and restart
//                 from the reload value on the next enabled edge.
module bcd_countdown_2digits #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    output logic [7:0] count,
    output logic       zero,
    output logic       done,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic [7:0] reload_reg, reload_next;
    logic       done_reg, done_next;
    logic [7:0] load_clamped;

    // Clamp each nibble of the load value into BCD range independently.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
            assign load_clamped[gi*4 +: 4] =
                (load_value[gi*4 +: 4] > 4'd9) ? 4'd9 : load_value[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= 8'h00;
            reload_reg <= 8'h00;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (load) begin
            count_next  = load_clamped;
            reload_next = load_clamped;
            state_next  = (load_clamped != 8'h00) ? RUN : IDLE;
        end else if (enable && (state_reg == RUN)) begin
            if (count_reg == 8'h00) begin
                // Only reachable with auto-reload: the edge after expiry
                // restarts from the captured value.
                count_next = reload_reg;
            end else if (count_reg == 8'h01) begin
                count_next = 8'h00;
                done_next  = 1'b1;
                state_next = AUTO_RELOAD ? RUN : IDLE;
            end else if (count_reg[3:0] != 4'd0) begin
                count_next = {count_reg[7:4], count_reg[3:0] - 4'd1};
            end else begin
                // Borrow from tens; tens cannot be 0 here since count > 01.
                count_next = {count_reg[7:4] - 4'd1, 4'd9};
            end
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == 8'h00);
    assign done  = done_reg;
    assign busy  = (state_reg == RUN);

endmodule

// File: doc/bcd_countdown_2digits.md
BCD_COUNTDOWN_2DIGITS -- requirements
Module: bcd_countdown_2digits

Interface
REQ-001 The parameter SHALL be AUTO_RELOAD, default 0: 0 = stop at 00; 1 = restart from the reload value after 00.
REQ-002 The port `clk` SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The port `reset` SHALL be input, 1 bit: reset, synchronous, active-high.
REQ-004 The port `load` SHALL be input, 1 bit: capture `load_value` on this edge.
REQ-005 The port `load_value` SHALL be input, 8 bits: BCD value, {tens[7:4], ones[3:0]}.
REQ-006 The port `enable` SHALL be input, 1 bit: count-down tick qualifier.
REQ-007 The port `count` SHALL be output, 8 bits: current BCD value, {tens, ones}, registered.
REQ-008 The port `zero` SHALL be output, 1 bit: high whenever count == 8'h00; combinational decode of `count`.
REQ-009 The port `done` SHALL be output, 1 bit: registered one-cycle pulse on the expiry transition.
REQ-010 The port `busy` SHALL be output, 1 bit: high while the FSM is in RUN.

Function
REQ-011 The FSM SHALL have two states. IDLE: halted. RUN: counting.
REQ-012 Edge priority SHALL be: reset > load > enable > hold.
REQ-013 Load sanitising SHALL clamp each nibble of `load_value` greater than 9 to 9 (8'h3F -> 8'h39, 8'hA2 -> 8'h92).
REQ-014 On load:
- `count` and an internal reload register SHALL take the sanitised value on the same edge.
- If that value is nonzero, the next state SHALL be RUN; otherwise it SHALL be IDLE.
- `done` SHALL be 0 on that edge.
REQ-015 In RUN with enable=1 and no load, the decrement SHALL be:
- ones != 0: ones-1.
- ones == 0: ones := 9 and tens := tens-1.
- `count` SHALL never leave BCD range.
REQ-016 Expiry is the edge where `count` goes 8'h01 -> 8'h00 in RUN. On that edge `done` SHALL be 1, and 0 on every other edge.
REQ-017 On expiry with AUTO_RELOAD=0, the state SHALL become IDLE and `count` SHALL hold 00 until the next load.
REQ-018 With AUTO_RELOAD=1, the state SHALL stay RUN after expiry, and the next enabled edge SHALL set `count` to the reload register with no `done`.
REQ-019 With enable=0, `count` and the state SHALL hold and `done` SHALL be 0.
REQ-020 In IDLE, enable SHALL have no effect: `count` holds and `done` stays 0.
REQ-021 A load coincident with a would-be expiry SHALL win: `count` takes the load value and `done` is 0.
REQ-022 A load during RUN SHALL restart the countdown from the new value with no `done`.
REQ-023 Latency from a load edge SHALL be N enabled edges to expiry, where N is the loaded value in decimal.

Reset
REQ-024 On reset=1 at a clock edge, the block SHALL set: `count` = 8'h00, reload register = 8'h00, `done` = 0, state = IDLE. Consequently `busy` = 0 and `zero` = 1.
REQ-025 Reset asserted mid-count SHALL take effect on the next edge regardless of load or enable.
REQ-026 Reset SHALL produce no `done` pulse.
REQ-027 Outputs before the first reset are don't-care.

Verification
REQ-028 Reset scenario: assert reset for 1 edge -> count=00, zero=1, done=0, busy=0.
REQ-029 Basic countdown scenario, AUTO_RELOAD=0: load 8'h12, then enable=1 continuously. Required response:
- count = 12, 11, 10, 09, ..., 01, 00.
- done=1 only on the 12th enabled edge.
- busy falls with the same edge.
- count holds 00 for 5 more edges.
REQ-030 Load-clamp scenario: load 8'h3F -> count=39; load 8'hA0 -> count=90; load 8'h00 -> count=00, busy=0, done never asserts.
REQ-031 Enable gating scenario: load 8'h05, enable pattern 1,0,0,1,1 -> count = 04, 04, 04, 03, 02, with done=0 throughout.
REQ-032 Auto-reload scenario: AUTO_RELOAD=1, load 8'h03, enable=1 -> count = 02, 01, 00 (done=1), 03, 02, 01, 00 (done=1), busy=1 throughout.
REQ-033 Collision scenarios:
- At count=01, assert load=1 with load_value=8'h20 and enable=1 -> count=20, done=0.
- At count=05 in RUN, assert reset with load=1 -> count=00, busy=0, done=0.
